i2c_regfile: RTL

Parametrised I2C-slave register file sitting behind the I2C byte-level slave PHY. It interprets the received byte stream: the first byte of a write transfer is a register pointer, and subsequent bytes are data. The pointer auto-increments on every data byte written or read. Registers flagged read-only return live status inputs, and every write raises a per-register strobe for downstream logic.

---
 rtl/i2c_regfile_pkg.sv | 38 +++
 rtl/i2c_reg_bank.sv | 77 +++++++
 rtl/i2c_regfile.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/i2c_regfile_pkg.sv
// -----------------------------------------------------------------------------
// i2c_regfile_pkg
// Shared definitions for the I2C register file:
//   - state_e      : transfer-level FSM states
//   - ALL_ONES     : default byte returned for illegal/out-of-range reads
//                    (slice the low DATA_W bits at the point of use)
//   - ptr_advance  : pointer auto-increment rule (wraps at the last
//                    register, parks when already out of range)
// -----------------------------------------------------------------------------
package i2c_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PTR = 2'd1,
        ST_DATA     = 2'd2
    } state_e;

    localparam int unsigned MAX_DATA_W = 32;

    localparam logic [MAX_DATA_W-1:0] ALL_ONES = '1;

    // An out-of-range pointer is left alone so a master streaming past the
    // end of the map keeps getting all-ones instead of wrapping into real
    // registers.
    function automatic logic [MAX_DATA_W-1:0] ptr_advance(
        input logic [MAX_DATA_W-1:0] ptr,
        input logic [MAX_DATA_W-1:0] num_regs
    );
        if (ptr == num_regs - MAX_DATA_W'(1)) begin
            return '0;
        end else if (ptr >= num_regs) begin
            return ptr;
        end else begin
            return ptr + MAX_DATA_W'(1);
        end
    endfunction

endpackage

// File: rtl/i2c_reg_bank.sv
// -----------------------------------------------------------------------------
// i2c_reg_bank
// Register storage for the I2C register file. One write port, one
// combinational read port, read-only slots sourced from live status.
//
// Ports:
//   i_sys_clk    system clock
//   i_rst        asynchronous active-high reset (storage -> RESET_VAL)
//   i_we         write request for address i_waddr
//   i_waddr      write address (pointer)
//   i_wdata      write data
//   i_raddr      read address (pointer)
//   i_status     flattened live values for read-only slots
//   o_rdata      combinational read data (all-ones when out of range)
//   o_regs       flattened register contents, read-only slots drive 0
//   o_wr_strobe  registered one-cycle pulse per register actually written
// -----------------------------------------------------------------------------
module i2c_reg_bank
    import i2c_regfile_pkg::*;
#(
    parameter int                          DATA_W    = 8,
    parameter int                          NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0]         RO_MASK   = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst,
    input  logic                          i_we,
    input  logic [DATA_W-1:0]             i_waddr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [DATA_W-1:0]             i_raddr,
    input  logic [NUM_REGS*DATA_W-1:0]    i_status,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [NUM_REGS*DATA_W-1:0]    o_regs,
    output logic [NUM_REGS-1:0]           o_wr_strobe
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] we_vec;
    logic [NUM_REGS-1:0] wr_strobe_q;

    // Decoding against each slot index means an out-of-range address simply
    // matches nothing, so dropped writes need no separate range check.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        assign we_vec[g] = i_we && (i_waddr == DATA_W'(g)) && !RO_MASK[g];

        always_ff @(posedge i_sys_clk or posedge i_rst) begin
            if (i_rst) begin
                regs_q[g] <= RESET_VAL[g*DATA_W +: DATA_W];
            end else if (we_vec[g]) begin
                regs_q[g] <= i_wdata;
            end
        end

        assign o_regs[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_strobe_q <= '0;
        end else begin
            wr_strobe_q <= we_vec;
        end
    end

    assign o_wr_strobe = wr_strobe_q;

    always_comb begin
        o_rdata = ALL_ONES[DATA_W-1:0];
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_raddr == DATA_W'(i)) begin
                o_rdata = RO_MASK[i] ? i_status[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

endmodule

// File: rtl/i2c_regfile.sv
// -----------------------------------------------------------------------------
// i2c_regfile
// I2C-slave register file behind the byte-level slave PHY. The first byte of
// a write transfer sets the register pointer; following bytes are written to
// successive registers. Master reads return successive registers. The pointer
// auto-increments on every data byte and survives STOP/START.
//
// Ports:
//   i_sys_clk    system clock
//   i_rst        asynchronous active-high reset
//   i_start      START / repeated START with own address matched (pulse)
//   i_rnw        R/W bit of the address byte, valid with i_start (1 = read)
//   i_stop       STOP seen (pulse)
//   i_rx_valid   byte received from master (pulse)
//   i_rx_data    received byte
//   i_tx_req     PHY needs next byte for a master read (pulse)
//   o_tx_data    byte to transmit, held until the next read
//   o_tx_valid   o_tx_data valid (pulse, one cycle after i_tx_req)
//   i_status     live values for read-only registers
//   o_regs       flattened register contents (read-only slots drive 0)
//   o_wr_strobe  one-cycle pulse per register written
//   o_pointer    current register pointer
//   o_proto_err  protocol violation (pulse)
// -----------------------------------------------------------------------------
module i2c_regfile
    import i2c_regfile_pkg::*;
#(
    parameter int                          DATA_W    = 8,
    parameter int                          NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0]         RO_MASK   = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = {NUM_REGS*DATA_W{1'b0}}
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_rnw,
    input  logic                          i_stop,
    input  logic                          i_rx_valid,
    input  logic [DATA_W-1:0]             i_rx_data,
    input  logic                          i_tx_req,
    output logic [DATA_W-1:0]             o_tx_data,
    output logic                          o_tx_valid,
    input  logic [NUM_REGS*DATA_W-1:0]    i_status,
    output logic [NUM_REGS*DATA_W-1:0]    o_regs,
    output logic [NUM_REGS-1:0]           o_wr_strobe,
    output logic [DATA_W-1:0]             o_pointer,
    output logic                          o_proto_err
);

    state_e              state_q;
    logic [DATA_W-1:0]   pointer_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                tx_valid_q;
    logic                proto_err_q;

    logic [DATA_W-1:0]   pointer_adv_d;
    logic [DATA_W-1:0]   bank_rdata;
    logic                bank_we;

    assign pointer_adv_d = DATA_W'(ptr_advance(MAX_DATA_W'(pointer_q),
                                               MAX_DATA_W'(NUM_REGS)));

    // STOP and START take priority over data bytes, so a byte arriving in the
    // same cycle as either must not reach the storage.
    assign bank_we = (state_q == ST_DATA) && i_rx_valid && !i_stop && !i_start;

    i2c_reg_bank #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .RO_MASK   (RO_MASK),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .i_sys_clk   (i_sys_clk),
        .i_rst       (i_rst),
        .i_we        (bank_we),
        .i_waddr     (pointer_q),
        .i_wdata     (i_rx_data),
        .i_raddr     (pointer_q),
        .i_status    (i_status),
        .o_rdata     (bank_rdata),
        .o_regs      (o_regs),
        .o_wr_strobe (o_wr_strobe)
    );

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            pointer_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            tx_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
            if (i_stop) begin
                state_q <= ST_IDLE;
            end else if (i_start) begin
                // A read transfer starts straight in DATA and reuses the
                // pointer left over from the previous transfer.
                state_q <= i_rnw ? ST_DATA : ST_WAIT_PTR;
            end else begin
                unique case (state_q)
                    ST_WAIT_PTR: begin
                        if (i_rx_valid) begin
                            pointer_q   <= i_rx_data;
                            state_q     <= ST_DATA;
                            proto_err_q <= i_tx_req;
                        end else if (i_tx_req) begin
                            // Master read before any pointer byte: answer with
                            // all-ones so the PHY is never starved.
                            proto_err_q <= 1'b1;
                            tx_valid_q  <= 1'b1;
                            tx_data_q   <= ALL_ONES[DATA_W-1:0];
                        end
                    end
                    ST_DATA: begin
                        if (i_rx_valid) begin
                            // Write wins over a coincident read; the read is
                            // dropped and flagged.
                            pointer_q   <= pointer_adv_d;
                            proto_err_q <= i_tx_req;
                        end else if (i_tx_req) begin
                            tx_data_q  <= bank_rdata;
                            tx_valid_q <= 1'b1;
                            pointer_q  <= pointer_adv_d;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_pointer   = pointer_q;
    assign o_proto_err = proto_err_q;

endmodule
